sequence_checker: RTL and testbench

// - Receive-side companion of the 4-bit JK sequence counter: samples the counter's Q[3:0] and checks it

---
 rtl/sequence_checker.sv | 182 ++++++++++++++++++
 tb/tb_sequence_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequence_checker.sv
// rtl/sequence_checker.sv - Johnson-ring sequence checker with lock, flywheel and optional error counter (SEQ_CHK_ERRCNT_EN)
module sequence_checker #(
    parameter int LOCK_CNT = 3,
    parameter int LOSS_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [3:0]       seq_in,
    input  logic             seq_vld,
    output logic             locked,
    output logic [2:0]       idx,
    output logic             idx_vld,
    output logic             seq_err,
    output logic             illegal,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [2:0] LOCK_MAX = 3'(LOCK_CNT);
    localparam logic [2:0] LOSS_MAX = 3'(LOSS_CNT);

    state_t     state;
    logic [3:0] prev;
    logic [2:0] good;
    logic [2:0] bad;

    logic       in_legal;
    logic [2:0] in_idx;
    logic [3:0] exp_code;
    logic [2:0] exp_idx;
    logic       match;

    // A code is legal iff it is one of the eight Johnson ring codes.
    function automatic logic is_legal(input logic [3:0] c);
        case (c)
            4'b0000, 4'b1000, 4'b1100, 4'b1110,
            4'b1111, 4'b0111, 4'b0011, 4'b0001: is_legal = 1'b1;
            default:                            is_legal = 1'b0;
        endcase
    endfunction

    // Ring position of a Johnson code; illegal codes map to 0 and are never used as positions.
    function automatic logic [2:0] code_idx(input logic [3:0] c);
        case (c)
            4'b1000: code_idx = 3'd1;
            4'b1100: code_idx = 3'd2;
            4'b1110: code_idx = 3'd3;
            4'b1111: code_idx = 3'd4;
            4'b0111: code_idx = 3'd5;
            4'b0011: code_idx = 3'd6;
            4'b0001: code_idx = 3'd7;
            default: code_idx = 3'd0;
        endcase
    endfunction

    // Decode the incoming sample and the predicted successor of the last tracked code.
    always_comb begin
        in_legal = is_legal(seq_in);
        in_idx   = code_idx(seq_in);
        exp_code = {~prev[0], prev[3:1]};
        exp_idx  = code_idx(exp_code);
        match    = (seq_in == exp_code);
    end

    // Lock FSM: acquire on LOCK_CNT consecutive successors, flywheel through bad samples, drop after LOSS_CNT.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= ST_IDLE;
            prev    <= 4'b0000;
            good    <= 3'd0;
            bad     <= 3'd0;
            locked  <= 1'b0;
            idx     <= 3'd0;
            idx_vld <= 1'b0;
            seq_err <= 1'b0;
            illegal <= 1'b0;
        end else begin
            idx_vld <= 1'b0;
            seq_err <= 1'b0;
            illegal <= 1'b0;
            if (seq_vld) begin
                case (state)
                    ST_IDLE: begin
                        if (in_legal) begin
                            state   <= ST_ACQ;
                            good    <= 3'd1;
                            prev    <= seq_in;
                            idx     <= in_idx;
                            idx_vld <= 1'b1;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                    ST_ACQ: begin
                        if (!in_legal) begin
                            illegal <= 1'b1;
                            state   <= ST_IDLE;
                            good    <= 3'd0;
                        end else if (match) begin
                            prev    <= seq_in;
                            idx     <= in_idx;
                            idx_vld <= 1'b1;
                            if ((good + 3'd1) >= LOCK_MAX) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                                good   <= LOCK_MAX;
                                bad    <= 3'd0;
                            end else begin
                                good <= good + 3'd1;
                            end
                        end else begin
                            // Legal but out of order: restart acquisition from this sample.
                            seq_err <= 1'b1;
                            good    <= 3'd1;
                            prev    <= seq_in;
                            idx     <= in_idx;
                            idx_vld <= 1'b1;
                        end
                    end
                    ST_LOCKED: begin
                        idx_vld <= 1'b1;
                        if (match) begin
                            bad  <= 3'd0;
                            prev <= seq_in;
                            idx  <= in_idx;
                        end else begin
                            // Flywheel: keep tracking at the predicted code.
                            if (!in_legal) begin
                                illegal <= 1'b1;
                            end else begin
                                seq_err <= 1'b1;
                            end
                            prev <= exp_code;
                            idx  <= exp_idx;
                            if ((bad + 3'd1) >= LOSS_MAX) begin
                                state  <= ST_IDLE;
                                locked <= 1'b0;
                                good   <= 3'd0;
                                bad    <= 3'd0;
                            end else begin
                                bad <= bad + 3'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                        good   <= 3'd0;
                        bad    <= 3'd0;
                    end
                endcase
            end
        end
    end

`ifdef SEQ_CHK_ERRCNT_EN
    logic err_ev;

    // Any sample that will pulse seq_err or illegal this edge.
    always_comb begin
        err_ev = seq_vld && (!in_legal || ((state != ST_IDLE) && !match));
    end

    // Saturating error event counter, cleared only by reset.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            err_cnt <= '0;
        end else if (err_ev && (err_cnt != {ERR_W{1'b1}})) begin
            err_cnt <= err_cnt + {{(ERR_W-1){1'b0}}, 1'b1};
        end
    end
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_sequence_checker.sv
// tb/tb_sequence_checker.sv - directed self-checking bench for sequence_checker
module tb_sequence_checker;

    localparam int ERR_W = 2;

    logic             clk;
    logic             clr;
    logic [3:0]       seq_in;
    logic             seq_vld;
    logic             locked;
    logic [2:0]       idx;
    logic             idx_vld;
    logic             seq_err;
    logic             illegal;
    logic [ERR_W-1:0] err_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    sequence_checker #(
        .LOCK_CNT(3),
        .LOSS_CNT(2),
        .ERR_W   (ERR_W)
    ) dut (
        .clk     (clk),
        .clr     (clr),
        .seq_in  (seq_in),
        .seq_vld (seq_vld),
        .locked  (locked),
        .idx     (idx),
        .idx_vld (idx_vld),
        .seq_err (seq_err),
        .illegal (illegal),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one sample, return at the following negedge with outputs settled.
    task automatic drv(input logic [3:0] c, input logic v);
        seq_in  = c;
        seq_vld = v;
        @(negedge clk);
    endtask

    task automatic do_reset;
        clr     = 1'b0;
        seq_vld = 1'b0;
        seq_in  = 4'b0000;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic do_lock;
        drv(4'b0000, 1'b1);
        drv(4'b1000, 1'b1);
        drv(4'b1100, 1'b1);
    endtask

    task automatic test_reset;
        do_reset();
        n_tests++;
        if ({locked, idx, idx_vld, seq_err, illegal} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_outs got=%b exp=0", {locked, idx, idx_vld, seq_err, illegal});
        end
        n_tests++;
        if (err_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset_errcnt got=%0d exp=0", err_cnt);
        end
        do_lock();
        n_tests++;
        if (locked !== 1'b1 || idx !== 3'd2) begin
            n_fail++;
            $display("FAIL reset_prelock locked=%b idx=%0d exp locked=1 idx=2", locked, idx);
        end
        #2 clr = 1'b0;
        #1;
        n_tests++;
        if ({locked, idx, idx_vld, seq_err, illegal} !== 7'd0) begin
            n_fail++;
            $display("FAIL reset_midrun got=%b exp=0", {locked, idx, idx_vld, seq_err, illegal});
        end
        @(negedge clk);
        clr = 1'b1;
        drv(4'b0000, 1'b1);
        n_tests++;
        if (idx_vld !== 1'b1 || idx !== 3'd0 || locked !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first idx_vld=%b idx=%0d locked=%b exp 1,0,0", idx_vld, idx, locked);
        end
    endtask

    task automatic test_lock;
        logic [3:0] codes [9];
        logic [2:0] exp_i [9];
        logic       exp_l [9];
        codes = '{4'b0000, 4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0111, 4'b0011, 4'b0001, 4'b0000};
        exp_i = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
        exp_l = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drv(codes[i], 1'b1);
            n_tests++;
            if (idx !== exp_i[i] || locked !== exp_l[i] || idx_vld !== 1'b1 ||
                seq_err !== 1'b0 || illegal !== 1'b0) begin
                n_fail++;
                $display("FAIL lock_step%0d idx=%0d locked=%b vld=%b err=%b ill=%b exp idx=%0d locked=%b vld=1 err=0 ill=0",
                         i, idx, locked, idx_vld, seq_err, illegal, exp_i[i], exp_l[i]);
            end
        end
    endtask

    task automatic test_glitch;
        do_reset();
        do_lock();
        drv(4'b1110, 1'b1);
        drv(4'b1010, 1'b1);
        n_tests++;
        if (illegal !== 1'b1 || seq_err !== 1'b0 || locked !== 1'b1 || idx !== 3'd4 || idx_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL glitch_hit ill=%b err=%b locked=%b idx=%0d vld=%b exp 1,0,1,4,1",
                     illegal, seq_err, locked, idx, idx_vld);
        end
        drv(4'b0111, 1'b1);
        n_tests++;
        if (illegal !== 1'b0 || seq_err !== 1'b0 || locked !== 1'b1 || idx !== 3'd5) begin
            n_fail++;
            $display("FAIL glitch_recover ill=%b err=%b locked=%b idx=%0d exp 0,0,1,5",
                     illegal, seq_err, locked, idx);
        end
    endtask

    task automatic test_loss;
        do_reset();
        do_lock();
        drv(4'b0000, 1'b1);
        n_tests++;
        if (seq_err !== 1'b1 || illegal !== 1'b0 || locked !== 1'b1 || idx !== 3'd3) begin
            n_fail++;
            $display("FAIL loss_first err=%b ill=%b locked=%b idx=%0d exp 1,0,1,3", seq_err, illegal, locked, idx);
        end
        drv(4'b1000, 1'b1);
        n_tests++;
        if (seq_err !== 1'b1 || locked !== 1'b0 || idx !== 3'd4) begin
            n_fail++;
            $display("FAIL loss_second err=%b locked=%b idx=%0d exp 1,0,4", seq_err, locked, idx);
        end
        drv(4'b1000, 1'b1);
        n_tests++;
        if (seq_err !== 1'b0 || locked !== 1'b0 || idx !== 3'd1 || idx_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL loss_reacq err=%b locked=%b idx=%0d vld=%b exp 0,0,1,1", seq_err, locked, idx, idx_vld);
        end
    endtask

    task automatic test_gaps;
        do_reset();
        do_lock();
        drv(4'b1110, 1'b1);
        drv(4'b1111, 1'b1);
        drv(4'b0111, 1'b1);
        drv(4'b0011, 1'b1);
        drv(4'b0001, 1'b1);
        drv(4'b0000, 1'b1);
        drv(4'b1000, 1'b1);
        n_tests++;
        if (idx !== 3'd1 || idx_vld !== 1'b1 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_first idx=%0d vld=%b locked=%b exp 1,1,1", idx, idx_vld, locked);
        end
        drv(4'b1010, 1'b0);
        n_tests++;
        if (idx !== 3'd1 || idx_vld !== 1'b0 || illegal !== 1'b0 || seq_err !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_idle1 idx=%0d vld=%b ill=%b err=%b locked=%b exp 1,0,0,0,1",
                     idx, idx_vld, illegal, seq_err, locked);
        end
        drv(4'b0101, 1'b0);
        n_tests++;
        if (idx !== 3'd1 || idx_vld !== 1'b0 || illegal !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_idle2 idx=%0d vld=%b ill=%b locked=%b exp 1,0,0,1", idx, idx_vld, illegal, locked);
        end
        drv(4'b1100, 1'b1);
        n_tests++;
        if (idx !== 3'd2 || idx_vld !== 1'b1 || seq_err !== 1'b0 || illegal !== 1'b0 || locked !== 1'b1) begin
            n_fail++;
            $display("FAIL gaps_resume idx=%0d vld=%b err=%b ill=%b locked=%b exp 2,1,0,0,1",
                     idx, idx_vld, seq_err, illegal, locked);
        end
    endtask

    task automatic test_acq_restart;
        do_reset();
        drv(4'b0000, 1'b1);
        drv(4'b1100, 1'b1);
        n_tests++;
        if (seq_err !== 1'b1 || locked !== 1'b0 || idx !== 3'd2) begin
            n_fail++;
            $display("FAIL acq_mismatch err=%b locked=%b idx=%0d exp 1,0,2", seq_err, locked, idx);
        end
        drv(4'b1110, 1'b1);
        n_tests++;
        if (locked !== 1'b0 || seq_err !== 1'b0) begin
            n_fail++;
            $display("FAIL acq_good2 locked=%b err=%b exp 0,0", locked, seq_err);
        end
        drv(4'b1111, 1'b1);
        n_tests++;
        if (locked !== 1'b1 || idx !== 3'd4) begin
            n_fail++;
            $display("FAIL acq_relock locked=%b idx=%0d exp 1,4", locked, idx);
        end
    endtask

    task automatic test_err_cnt;
        logic [3:0]       codes [5];
        logic [ERR_W-1:0] exp_c [5];
        codes = '{4'b1010, 4'b0101, 4'b1001, 4'b0100, 4'b1101};
`ifdef SEQ_CHK_ERRCNT_EN
        exp_c = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
        exp_c = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv(codes[i], 1'b1);
            n_tests++;
            if (illegal !== 1'b1 || err_cnt !== exp_c[i] || locked !== 1'b0) begin
                n_fail++;
                $display("FAIL errcnt_step%0d ill=%b cnt=%0d locked=%b exp 1,%0d,0",
                         i, illegal, err_cnt, locked, exp_c[i]);
            end
        end
    endtask

    initial begin
        clr     = 1'b0;
        seq_in  = 4'b0000;
        seq_vld = 1'b0;
        test_reset();
        test_lock();
        test_glitch();
        test_loss();
        test_gaps();
        test_acq_restart();
        test_err_cnt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
